io_intr_ctrl: RTL
=================

# io_intr_ctrl

Parametrised multi-channel interrupt controller for the MIPS baseline CPU's I/O space. It replaces the single-line I/O interrupt path with NUM_CH synchronised sources, each with per-channel mask and edge/level mode. Sources are resolved by fixed priority into one intr_req/intr_ack handshake with the CPU. Software reads the winning channel ID from a memory-mapped vector register and closes service with an end-of-interrupt (EOI) write. The block sits on the same ALU_OUT[11:0] / D_OUT / IO_wr / IO_rd bus as the existing I/O memory.

## Interface
- NUM_CH, 8: number of interrupt sources, 1..32; channel 0 has the highest priority.
- ADDR_W, 12: I/O address width.
- DATA_W, 32: data bus width.
- BASE_ADDR, 12'hF00: base of the register window. Must be 32-byte aligned.
- Clock and reset: one clock, `sys_clk`. Reset is `reset`, asynchronous and active-low.
- sys_clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- intr  in  NUM_CH  raw interrupt sources, asynchronous to sys_clk.
- Addr  in  ADDR_W  byte address (ALU_OUT[11:0]).
- D_In  in  DATA_W  write data (D_OUT).
- IO_wr  in  1  I/O write strobe.
- IO_rd  in  1  I/O read strobe.
- intr_ack  in  1  CPU acknowledge, level; only its rising edge is used.
- intr_req  out  1  interrupt request to the CPU, registered.
- IO_D_Out  out  DATA_W  read data.

## Operation
- Register window, offsets from BASE_ADDR; an access hits only when Addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]:
  - 0x00 PEND: read; write-1-to-clear, edge channels only.
  - 0x04 MASK: read/write; 1 = enabled.
  - 0x08 MODE: read/write; 1 = edge, 0 = level.
  - 0x0C VECTOR: read only; bit 31 = valid, bits [4:0] = channel ID.
  - 0x10 EOI: write; data ignored.
- Unused offsets and unused upper bits read 0. Writes to them are ignored.
- Source input path: each intr[i] passes through a 2-flop synchroniser, then a previous-value flop.
- Pending, edge channel: set on a synchronised 0→1 transition. Cleared by PEND W1C, or by an acknowledge that selects this channel.
- Pending, level channel: PEND[i] follows the synchronised input. W1C and acknowledge have no effect on it.
- Active channels = PEND & MASK. The winner is the lowest-index active bit.
- State machine:
  - IDLE: intr_req=0. Go to REQ when any channel is active.
  - REQ: intr_req=1.
    - On an intr_ack rising edge: latch VECTOR = {1, winner}, clear the winner's PEND if it is an edge channel, go to SERVICE.
    - If the active set becomes empty before the acknowledge: return to IDLE (request withdrawn).
  - SERVICE: intr_req=0, no nesting. An EOI write goes to IDLE and clears VECTOR.valid.
- Acknowledge outside REQ (spurious): VECTOR = {0, 5'h1F}, no state change.
- Simultaneous W1C and new edge on the same channel: set wins.
- Simultaneous EOI and intr_ack edge in SERVICE: EOI is taken; the acknowledge is spurious.
- Reset values: intr_req=0, IO_D_Out=0, PEND=0, MASK=0, MODE=all 1, VECTOR=0, state IDLE, all sync/edge flops 0. Reset asserted mid-service returns every register to these values immediately.

## Timing
- intr[i] first sampled high at edge k:
  - sync2 high at edge k+1;
  - PEND[i] set at edge k+2;
  - intr_req high after edge k+3, when the channel is masked on and the block is in IDLE.
- intr_ack high at edge a (previous-value flop low): VECTOR and PEND update at edge a, and intr_req is low after edge a.
- Reads: IO_D_Out is combinational from Addr when IO_rd and the access hits; otherwise 0. Zero-cycle latency.
- Writes take effect at the rising edge where IO_wr=1 and the access hits.
- EOI written at edge e: IDLE after e. If any channel is still active, intr_req is high after e+1.

## Structure
- Package io_intr_pkg: register offsets (PEND/MASK/MODE/VECTOR/EOI), state enum {IDLE, REQ, SERVICE}, spurious ID constant 5'h1F.
- Sub-module io_intr_sync_edge: per-channel 2-flop synchroniser plus rise detector, instantiated NUM_CH times. Priority encoder and register file live in the top.

## Test plan
- Single edge source: MASK=0x01, pulse intr[0] → intr_req rises 3 cycles after the sample edge. intr_ack → VECTOR reads 0x8000_0000, PEND reads 0. EOI → intr_req stays 0.
- Priority: MASK=0xFF, intr[5] and intr[2] rise together → VECTOR=0x8000_0002 after acknowledge. After EOI, intr_req re-asserts and the next VECTOR=0x8000_0005.
- Level mode: MODE=0xFE, intr[0] held high → acknowledge, then EOI, then intr_req re-asserts. Dropping intr[0] clears PEND[0] 2 cycles later. A W1C of 0x01 has no effect.
- Masking and withdraw: MASK=0, pulse intr[3] → PEND=0x08, intr_req stays 0. Write MASK=0x08 → intr_req asserts. W1C 0x08 before acknowledge → intr_req drops, state returns to IDLE.
- Spurious and simultaneous events: intr_ack in IDLE → VECTOR=0x0000_001F. W1C 0x10 on the same edge as a new rise of intr[4] → PEND[4]=1.
- Reset mid-service: in SERVICE, pull reset low → intr_req=0, PEND=0, MASK=0, MODE=0xFF, VECTOR=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/io_intr_pkg.sv
// Shared register map, FSM state encoding and constants for the I/O interrupt controller.
package io_intr_pkg;

    localparam logic [4:0] OFF_PEND   = 5'h00;
    localparam logic [4:0] OFF_MASK   = 5'h04;
    localparam logic [4:0] OFF_MODE   = 5'h08;
    localparam logic [4:0] OFF_VECTOR = 5'h0C;
    localparam logic [4:0] OFF_EOI    = 5'h10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_SERVICE = 2'd2;

    // Channel ID reported when an acknowledge arrives with nothing to grant.
    localparam logic [4:0] SPURIOUS_ID = 5'h1F;

endpackage

// File: rtl/io_intr_sync_edge.sv
// One interrupt source: 2-flop synchroniser followed by a previous-value flop
// that provides a single-cycle rise indication.
module io_intr_sync_edge (
    input  logic sys_clk,
    input  logic reset,
    input  logic src,
    output logic level,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain and previous-value flop.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= src;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/io_intr_ctrl.sv
// Multi-channel interrupt controller on the I/O bus: per-channel mask and
// edge/level mode, fixed priority, single req/ack handshake with EOI close.
module io_intr_ctrl
    import io_intr_pkg::*;
#(
    parameter int                NUM_CH    = 8,
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hF00
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] intr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] D_In,
    input  logic              IO_wr,
    input  logic              IO_rd,
    input  logic              intr_ack,
    output logic              intr_req,
    output logic [DATA_W-1:0] IO_D_Out
);

    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] pend_r;
    logic [NUM_CH-1:0] mask_r;
    logic [NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0] active_s;
    logic [NUM_CH-1:0] w1c_s;
    logic [NUM_CH-1:0] ack_clr_s;
    logic [NUM_CH-1:0] pend_nxt_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              vec_valid_r;
    logic              vec_valid_nxt_s;
    logic [4:0]        vec_id_r;
    logic [4:0]        vec_id_nxt_s;
    logic [4:0]        winner_s;
    logic              ack_prev_r;
    logic              intr_req_r;
    logic              ack_rise_s;
    logic              any_s;
    logic              accept_s;
    logic              spurious_s;
    logic              hit_s;
    logic              wr_hit_s;
    logic              eoi_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              unused_s;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            io_intr_sync_edge u_sync (
                .sys_clk (sys_clk),
                .reset   (reset),
                .src     (intr[i]),
                .level   (sync_s[i]),
                .rise    (rise_s[i])
            );
        end
    endgenerate

    assign hit_s      = (Addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
    assign wr_hit_s   = IO_wr && hit_s;
    assign eoi_s      = wr_hit_s && (Addr[4:0] == OFF_EOI);
    assign w1c_s      = (wr_hit_s && (Addr[4:0] == OFF_PEND)) ? D_In[NUM_CH-1:0] : {NUM_CH{1'b0}};
    assign active_s   = pend_r & mask_r;
    assign any_s      = |active_s;
    assign ack_rise_s = intr_ack && !ack_prev_r;
    assign accept_s   = (state_r == ST_REQ) && ack_rise_s && any_s;
    assign spurious_s = ack_rise_s && !accept_s;
    assign unused_s   = ^D_In;

    // Fixed priority: scanning downward leaves the lowest active index.
    always_comb begin
        winner_s = 5'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            winner_s = active_s[i] ? 5'(i) : winner_s;
        end
    end

    // Pending update; a new rise overrides both W1C and acknowledge clears.
    always_comb begin
        ack_clr_s  = {NUM_CH{1'b0}};
        pend_nxt_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            ack_clr_s[i]  = accept_s && (winner_s == 5'(i));
            pend_nxt_s[i] = mode_r[i] ? ((pend_r[i] & ~w1c_s[i] & ~ack_clr_s[i]) | rise_s[i])
                                      : sync_s[i];
        end
    end

    // Request/service handshake state machine.
    always_comb begin
        state_nxt_s     = state_r;
        vec_valid_nxt_s = vec_valid_r;
        vec_id_nxt_s    = vec_id_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = any_s ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                if (accept_s) begin
                    state_nxt_s     = ST_SERVICE;
                    vec_valid_nxt_s = 1'b1;
                    vec_id_nxt_s    = winner_s;
                end else if (!any_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eoi_s) begin
                    state_nxt_s     = ST_IDLE;
                    vec_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, vector and register file.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            intr_req_r  <= 1'b0;
            ack_prev_r  <= 1'b0;
            pend_r      <= {NUM_CH{1'b0}};
            mask_r      <= {NUM_CH{1'b0}};
            mode_r      <= {NUM_CH{1'b1}};
            vec_valid_r <= 1'b0;
            vec_id_r    <= 5'd0;
        end else begin
            state_r     <= state_nxt_s;
            intr_req_r  <= (state_nxt_s == ST_REQ);
            ack_prev_r  <= intr_ack;
            pend_r      <= pend_nxt_s;
            vec_valid_r <= spurious_s ? 1'b0 : vec_valid_nxt_s;
            vec_id_r    <= spurious_s ? SPURIOUS_ID : vec_id_nxt_s;
            if (wr_hit_s && (Addr[4:0] == OFF_MASK)) begin
                mask_r <= D_In[NUM_CH-1:0];
            end
            if (wr_hit_s && (Addr[4:0] == OFF_MODE)) begin
                mode_r <= D_In[NUM_CH-1:0];
            end
        end
    end

    // Zero-latency read mux; misses and unused offsets return zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        if (IO_rd && hit_s) begin
            case (Addr[4:0])
                OFF_PEND:   rd_data_s[NUM_CH-1:0] = pend_r;
                OFF_MASK:   rd_data_s[NUM_CH-1:0] = mask_r;
                OFF_MODE:   rd_data_s[NUM_CH-1:0] = mode_r;
                OFF_VECTOR: begin
                    rd_data_s[31]  = vec_valid_r;
                    rd_data_s[4:0] = vec_id_r;
                end
                default:    rd_data_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    assign intr_req = intr_req_r;
    assign IO_D_Out = rd_data_s;

endmodule
